// File: rtl/adder_operand_loader_if.sv
// Operand hand-off bus between the operand loader (master) and the adder (slave).
interface adder_operand_loader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;
    logic             op_ready;

    modport master (output op_a, output op_b, output op_valid, input op_ready);
    modport slave  (input op_a, input op_b, input op_valid, output op_ready);
endinterface

// File: rtl/adder_operand_loader.sv
// Collects two operand bytes from a pin-strobed bus and offers them to the adder over valid/ready.
// Optional GOT_A abandon timer is enabled by defining LOADER_TIMEOUT_EN.
module adder_operand_loader #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          data_stb,
    input  logic                          clear,
    adder_operand_loader_if.master        bus,
    output logic [1:0]                    state,
    output logic                          overrun,
    output logic                          timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GOT_A = 2'b01,
        ISSUE = 2'b10
    } state_t;

    if (SYNC_STAGES < 2) begin : g_sync_chk
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_tmo_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   edge_r;
    logic                   stb_rise_s;
    state_t                 state_r;
    logic [WIDTH-1:0]       op_a_r;
    logic [WIDTH-1:0]       op_b_r;
    logic                   op_valid_r;
    logic                   overrun_r;

`ifdef LOADER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_r;
    logic             timeout_r;
`endif

    // Strobe synchroniser and edge flop; free-running so strobes seen while disabled are consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], data_stb};
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign stb_rise_s = sync_r[SYNC_STAGES-1] & ~edge_r;

    // Loader FSM with registered operand, handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            op_a_r     <= '0;
            op_b_r     <= '0;
            op_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            cnt_r      <= '0;
            timeout_r  <= 1'b0;
`endif
        end else if (ena) begin
            if (clear) begin
                state_r    <= IDLE;
                op_valid_r <= 1'b0;
                overrun_r  <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
                cnt_r      <= '0;
                timeout_r  <= 1'b0;
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        if (stb_rise_s) begin
                            op_a_r  <= data_in;
                            state_r <= GOT_A;
`ifdef LOADER_TIMEOUT_EN
                            cnt_r   <= '0;
`endif
                        end
                    end
                    GOT_A: begin
                        // A strobe on the expiry cycle still completes the pair.
                        if (stb_rise_s) begin
                            op_b_r     <= data_in;
                            op_valid_r <= 1'b1;
                            state_r    <= ISSUE;
`ifdef LOADER_TIMEOUT_EN
                        end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            state_r   <= IDLE;
                            timeout_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
`endif
                        end
                    end
                    ISSUE: begin
                        if (op_valid_r && bus.op_ready) begin
                            op_valid_r <= 1'b0;
                            if (stb_rise_s) begin
                                op_a_r  <= data_in;
                                state_r <= GOT_A;
`ifdef LOADER_TIMEOUT_EN
                                cnt_r   <= '0;
`endif
                            end else begin
                                state_r <= IDLE;
                            end
                        end else if (stb_rise_s) begin
                            overrun_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        op_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.op_a     = op_a_r;
    assign bus.op_b     = op_b_r;
    assign bus.op_valid = op_valid_r;
    assign state        = state_r;
    assign overrun      = overrun_r;
`ifdef LOADER_TIMEOUT_EN
    assign timeout      = timeout_r;
`else
    assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed, table-driven bench for adder_operand_loader plus hand-written corner sequences.
module tb_adder_operand_loader;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] data_in;
    logic       data_stb;
    logic       clear;
    logic [1:0] state;
    logic       overrun;
    logic       timeout;

    int n_checks;
    int n_fail;

    adder_operand_loader_if #(.WIDTH(8)) bus ();

    adder_operand_loader #(
        .WIDTH          (8),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .data_in  (data_in),
        .data_stb (data_stb),
        .clear    (clear),
        .bus      (bus),
        .state    (state),
        .overrun  (overrun),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Raise the strobe just after an edge; the byte is captured on the third following edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        data_in  = b;
        data_stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        data_stb = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        data_in  = 8'h00;
        data_stb = 1'b0;
        clear    = 1'b0;
        bus.op_ready = 1'b0;

        vecs[0] = '{a: 8'h12, b: 8'h34, exp_a: 8'h12, exp_b: 8'h34};
        vecs[1] = '{a: 8'hFF, b: 8'h01, exp_a: 8'hFF, exp_b: 8'h01};
        vecs[2] = '{a: 8'h00, b: 8'hFF, exp_a: 8'h00, exp_b: 8'hFF};
        vecs[3] = '{a: 8'hA5, b: 8'h5A, exp_a: 8'hA5, exp_b: 8'h5A};
        vecs[4] = '{a: 8'h80, b: 8'h7F, exp_a: 8'h80, exp_b: 8'h7F};

        repeat (3) @(posedge clk);
        #2;
        check("rst_state", 32'(state), 32'h0);
        check("rst_op_a", 32'(bus.op_a), 32'h0);
        check("rst_op_b", 32'(bus.op_b), 32'h0);
        check("rst_valid", 32'(bus.op_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;

        // Pair loading with the adder always ready: valid lasts exactly one cycle.
        bus.op_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].a);
            check("vec_a_state", 32'(state), 32'h1);
            check("vec_a_op_a", 32'(bus.op_a), 32'(vecs[i].exp_a));
            send_byte(vecs[i].b);
            check("vec_b_valid", 32'(bus.op_valid), 32'h1);
            check("vec_b_state", 32'(state), 32'h2);
            check("vec_b_op_a", 32'(bus.op_a), 32'(vecs[i].exp_a));
            check("vec_b_op_b", 32'(bus.op_b), 32'(vecs[i].exp_b));
            @(posedge clk);
            #1;
            check("vec_done_valid", 32'(bus.op_valid), 32'h0);
            check("vec_done_state", 32'(state), 32'h0);
            check("vec_done_op_b", 32'(bus.op_b), 32'(vecs[i].exp_b));
        end

        // Strobe-to-capture latency.
        @(posedge clk);
        #1;
        data_in  = 8'h3C;
        data_stb = 1'b1;
        @(posedge clk); #1;
        check("lat_e1_state", 32'(state), 32'h0);
        @(posedge clk); #1;
        check("lat_e2_state", 32'(state), 32'h0);
        @(posedge clk); #1;
        check("lat_e3_state", 32'(state), 32'h1);
        check("lat_e3_op_a", 32'(bus.op_a), 32'h3C);
        data_stb = 1'b0;
        do_clear();
        check("clr_state", 32'(state), 32'h0);
        check("clr_keep_a", 32'(bus.op_a), 32'h3C);

        // Overrun while the adder stalls.
        bus.op_ready = 1'b0;
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h55);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_op_a", 32'(bus.op_a), 32'hFF);
        check("ovr_op_b", 32'(bus.op_b), 32'h01);
        check("ovr_valid", 32'(bus.op_valid), 32'h1);
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        check("ovr_xfer_valid", 32'(bus.op_valid), 32'h0);
        check("ovr_xfer_state", 32'(state), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);
        do_clear();
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Strobe lands on the transfer edge: byte becomes the new op_a.
        bus.op_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        @(posedge clk);
        #1;
        data_in  = 8'h77;
        data_stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 bus.op_ready = 1'b1;
        @(posedge clk); #1;
        check("coin_valid", 32'(bus.op_valid), 32'h0);
        check("coin_op_a", 32'(bus.op_a), 32'h77);
        check("coin_op_b", 32'(bus.op_b), 32'h22);
        check("coin_state", 32'(state), 32'h1);
        check("coin_overrun", 32'(overrun), 32'h0);
        data_stb = 1'b0;
        do_clear();

        // Asynchronous reset in the middle of a pair.
        send_byte(8'h9A);
        check("mid_op_a", 32'(bus.op_a), 32'h9A);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'h0);
        check("mid_rst_op_a", 32'(bus.op_a), 32'h0);
        check("mid_rst_valid", 32'(bus.op_valid), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        send_byte(8'h01);
        send_byte(8'h02);
        check("post_rst_valid", 32'(bus.op_valid), 32'h1);
        check("post_rst_op_a", 32'(bus.op_a), 32'h01);
        check("post_rst_op_b", 32'(bus.op_b), 32'h02);
        @(posedge clk); #1;
        check("post_rst_state", 32'(state), 32'h0);

        // GOT_A with no second strobe.
        send_byte(8'h42);
        check("tmo_entry_state", 32'(state), 32'h1);
        repeat (20) @(posedge clk);
        #1;
`ifdef LOADER_TIMEOUT_EN
        check("tmo_state", 32'(state), 32'h0);
        check("tmo_flag", 32'(timeout), 32'h1);
        check("tmo_valid", 32'(bus.op_valid), 32'h0);
        check("tmo_keep_a", 32'(bus.op_a), 32'h42);
`else
        check("tmo_state", 32'(state), 32'h1);
        check("tmo_flag", 32'(timeout), 32'h0);
        check("tmo_valid", 32'(bus.op_valid), 32'h0);
`endif
        do_clear();

        // Strobe while disabled is lost.
        ena = 1'b0;
        send_byte(8'h66);
        repeat (2) @(posedge clk);
        #1 ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("dis_state", 32'(state), 32'h0);
        check("dis_op_a", 32'(bus.op_a), 32'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
